// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM serializer slice.
package tdm_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_N_CH = 4;

endpackage

// File: rtl/tdm_serializer_mux.sv
// 4:1 bit multiplexer: O = I[S].
module tdm_serializer_mux (
    input  logic [3:0] I,
    input  logic [1:0] S,
    output logic       O
);

    always_comb begin
        O = 1'b0;
        case (S)
            2'd0: O = I[0];
            2'd1: O = I[1];
            2'd2: O = I[2];
            2'd3: O = I[3];
            default: O = 1'b0;
        endcase
    end

endmodule

// File: rtl/tdm_serializer.sv
// Parallel-to-serial TDM feeder: latches a word and walks a channel select through it,
// presenting one bit per output beat with start/end-of-frame markers.
module tdm_serializer
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH  = DEFAULT_N_CH,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sof_o,
    output logic             eof_o
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    sel_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (sel_q != LAST_SEL) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else if (in_valid) begin
                        // Last beat and a new word on the same edge: no bubble.
                        hold_d = in_data;
                        sel_d  = '0;
                    end else begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == SHIFT);
    assign in_ready  = (state_q == IDLE) || ((sel_q == LAST_SEL) && out_ready);
    assign sel_o     = sel_q;
    assign sof_o     = out_valid && (sel_q == '0);
    assign eof_o     = out_valid && (sel_q == LAST_SEL);

    generate
        if (N_CH == 4) begin : g_mux4
            tdm_serializer_mux u_mux (
                .I (hold_q),
                .S (sel_q),
                .O (ser_o)
            );
        end else begin : g_index
            assign ser_o = hold_q[sel_q];
        end
    endgenerate

endmodule

// File: tb/tb_tdm_serializer.sv
// Directed bench for tdm_serializer: N_CH=4 instance for framing/handshake, N_CH=8 for width.
module tb_tdm_serializer;

    logic       clk;
    logic       reset;

    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_o;
    logic [1:0] sel_o;
    logic       out_valid;
    logic       out_ready;
    logic       sof_o;
    logic       eof_o;

    logic [7:0] in_data8;
    logic       in_valid8;
    logic       in_ready8;
    logic       ser8;
    logic [2:0] sel8;
    logic       out_valid8;
    logic       out_ready8;
    logic       sof8;
    logic       eof8;

    int checks = 0;
    int errors = 0;

    tdm_serializer #(.N_CH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_o     (ser_o),
        .sel_o     (sel_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sof_o     (sof_o),
        .eof_o     (eof_o)
    );

    tdm_serializer #(.N_CH(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .ser_o     (ser8),
        .sel_o     (sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sof_o     (sof8),
        .eof_o     (eof8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int sel, input logic bit_v);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " sel"},   32'(sel_o),     32'(sel));
        check({tag, " ser"},   32'(ser_o),     32'(bit_v));
        check({tag, " sof"},   32'(sof_o),     32'(sel == 0));
        check({tag, " eof"},   32'(eof_o),     32'(sel == 3));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " rdy"},   32'(in_ready),  32'd1);
        check({tag, " sof"},   32'(sof_o),     32'd0);
        check({tag, " eof"},   32'(eof_o),     32'd0);
    endtask

    initial begin
        logic [3:0] seq4;
        logic [7:0] seq8;
        logic [7:0] b2b;

        reset      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_data8   = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        #12;
        check("rst sel", 32'(sel_o), 32'd0);
        check("rst ser", 32'(ser_o), 32'd0);
        chk_idle("rst");
        reset = 1'b1;
        step();

        // Single frame 1011
        seq4 = 4'b1011;
        in_data  = seq4;
        in_valid = 1'b1;
        check("sf accept rdy", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("sf b%0d", k), k, seq4[k]);
            if (k == 3) check("sf last rdy", 32'(in_ready), 32'd1);
            step();
        end
        chk_idle("sf end");

        // Back-to-back 0110 then 1001
        b2b      = 8'b1001_0110;
        in_data  = 4'b0110;
        in_valid = 1'b1;
        step();
        in_data  = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            chk_beat($sformatf("b2b b%0d", k), k % 4, b2b[k]);
            if (k < 4) check($sformatf("b2b rdy%0d", k), 32'(in_ready), 32'(k == 3));
            step();
            if (k == 3) in_valid = 1'b0;
        end
        chk_idle("b2b end");

        // Backpressure on beat 2 of 1100
        in_data  = 4'b1100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("bp b0", 0, 1'b0);
        step();
        chk_beat("bp b1", 1, 1'b0);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_beat($sformatf("bp hold%0d", k), 2, 1'b1);
            step();
        end
        out_ready = 1'b1;
        chk_beat("bp b2", 2, 1'b1);
        step();
        chk_beat("bp b3", 3, 1'b1);
        step();
        chk_idle("bp end");

        // Busy rejection: 1111 offered during beat 1 of 0001
        seq8     = 8'b1111_0001;
        in_data  = 4'b0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_beat("busy b0", 0, seq8[0]);
        step();
        in_data  = 4'b1111;
        in_valid = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk_beat($sformatf("busy b%0d", k), k % 4, seq8[k]);
            if (k < 4) check($sformatf("busy rdy%0d", k), 32'(in_ready), 32'(k == 3));
            step();
            if (k == 3) in_valid = 1'b0;
        end
        chk_idle("busy end");

        // Reset mid-frame after two beats of 1011
        in_data  = 4'b1011;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid sel pre", 32'(sel_o), 32'd2);
        reset = 1'b0;
        #1;
        check("mid sel", 32'(sel_o), 32'd0);
        check("mid ser", 32'(ser_o), 32'd0);
        chk_idle("mid rst");
        step();
        #2 reset = 1'b1;
        step();
        step();
        chk_idle("mid post");

        // N_CH=8, word A5
        seq8      = 8'hA5;
        in_data8  = seq8;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("w8 valid%0d", k), 32'(out_valid8), 32'd1);
            check($sformatf("w8 sel%0d", k),   32'(sel8),       32'(k));
            check($sformatf("w8 ser%0d", k),   32'(ser8),       32'(seq8[k]));
            check($sformatf("w8 eof%0d", k),   32'(eof8),       32'(k == 7));
            step();
        end
        check("w8 end valid", 32'(out_valid8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_serializer.md
Name: tdm_serializer

Overview:
- Upstream feeder for the 4:1 bit multiplexer.
- Accepts a parallel N_CH-bit word over a valid/ready handshake and holds it in a register.
- Steps a select counter through channels 0..N_CH-1, one channel per accepted output beat. The instantiated mux presents each selected bit as a serial stream with frame markers.
- Sits between a word-producing source and a serial link or TDM consumer. The consumer is typically the demultiplexor-based deserializer downstream.

Parameters:
- N_CH, 4, number of channels (word width); must be a power of 2, minimum 2.
- SEL_W, $clog2(N_CH), select width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = asserted).
- in_data  input  N_CH  parallel word; bit k is channel k.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_o  output  1  current serial bit, equal to hold_reg[sel_o].
- sel_o  output  SEL_W  current channel index (same value driven to the mux S input).
- out_valid  output  1  ser_o / sel_o are valid.
- out_ready  input  1  consumer accepts the current bit.
- sof_o  output  1  start of frame: out_valid && sel_o == 0.
- eof_o  output  1  end of frame: out_valid && sel_o == N_CH-1.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low: reset low forces the reset state immediately, independent of clk.
- Reset values: state=IDLE, hold_reg=0, sel_o=0, out_valid=0, ser_o=0, sof_o=0, eof_o=0, in_ready=1.
- Input handshake: a word is accepted on a rising edge where in_valid && in_ready. The source holds in_data stable while in_valid && !in_ready.
- Output handshake: a beat completes on a rising edge where out_valid && out_ready. With out_ready low, ser_o, sel_o and the frame flags hold unchanged.
- State machine, IDLE to SHIFT:
  - IDLE: in_ready=1, out_valid=0.
  - On accept: hold_reg<=in_data, sel<=0, go to SHIFT.
- SHIFT behaviour: out_valid=1.
  - On a completed beat with sel<N_CH-1: sel<=sel+1.
  - On a completed beat with sel==N_CH-1, no new word: go to IDLE, sel<=0.
- in_ready is combinational: (state==IDLE) || (sel==N_CH-1 && out_ready).
- Back-to-back frames: last beat completes and a new word is accepted on the same edge. hold_reg<=new word, sel wraps to 0, state stays SHIFT, out_valid stays 1 with no bubble.
- Latency: word accepted at edge t, bit 0 visible after edge t. With out_ready held high, bit k is visible after edge t+k.
- Throughput: one word per N_CH cycles sustained.
- ser_o is derived combinationally from registered hold_reg and sel, so there are no combinational paths from in_* to out_*. in_ready depends combinationally on out_ready only.
- Words offered while in SHIFT, not on the last beat: in_ready=0 and the word is not taken. No words are dropped.
- Reset mid-frame: the partial frame is discarded and outputs return to reset values immediately. After release, the block waits in IDLE.
- sel counts modulo N_CH and never exceeds N_CH-1.

Decomposition:
- Shared package tdm_pkg holds:
  - typedef state_t {IDLE, SHIFT}
  - localparam DEFAULT_N_CH = 4
- Sub-module: the existing mux instantiated for the N_CH=4 case, with I=hold_reg, S=sel, O=ser_o.
- For other N_CH, an indexed select replaces the mux instance, under a generate branch.
- No other sub-modules.

Test Plan:
1. Reset sanity: reset=0 mid-run (after loading 4'b1011 and 2 beats) → outputs immediately return to reset values (in_ready=1, out_valid=0); after release, stays IDLE.
2. Single frame: in_data=4'b1011 with out_ready=1 → ser_o sequence 1,1,0,1 with sel_o 0,1,2,3; sof_o on beat 0, eof_o on beat 3; then out_valid=0.
3. Back-to-back: words 4'b0110 then 4'b1001 with in_valid held → 8 consecutive valid beats 0,1,1,0,1,0,0,1 with no gap; in_ready high only in the cycle of the first word's last beat.
4. Backpressure: 4'b1100, out_ready low for 3 cycles on beat 2 → sel_o=2, ser_o=1 held stable; sequence resumes 1,1 afterwards with no beat lost or duplicated.
5. Busy rejection: in_valid with 4'b1111 during beat 1 of 4'b0001 → not accepted until the last beat; output sequence 1,0,0,0,1,1,1,1.
6. Parameter check: N_CH=8, word 8'hA5 → 8 beats LSB-first 1,0,1,0,0,1,0,1; eof_o at sel_o=7.
